// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the raster generator: the 640x480@60 set,
// a bundle type for a complete timing description and the total helper.
package video_timing_pkg;

    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    localparam timing_t VGA640_TIMING = '{
        h_active: VGA640_H_ACTIVE,
        h_fp:     VGA640_H_FP,
        h_sync:   VGA640_H_SYNC,
        h_bp:     VGA640_H_BP,
        v_active: VGA640_V_ACTIVE,
        v_fp:     VGA640_V_FP,
        v_sync:   VGA640_V_SYNC,
        v_bp:     VGA640_V_BP,
        hs_pol:   1'b0,
        vs_pol:   1'b0
    };

    function automatic int unsigned total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: counts active, front porch, sync, back porch and flags
// the active and sync regions of the current count.
module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned FP     = VGA640_H_FP,
    parameter int unsigned SYNC   = VGA640_H_SYNC,
    parameter int unsigned BP     = VGA640_H_BP,
    localparam int unsigned TOTAL = total(ACTIVE, FP, SYNC, BP),
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    if (TOTAL < 2 || TOTAL > (1 << W)) begin : g_bad_total
        $error("sync_axis_counter: axis total %0d does not fit %0d bits", TOTAL, W);
    end

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG   = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign wrap      = (count_q == LAST);
    assign in_active = (count_q < ACTIVE_END);
    // With no back porch the sync end equals TOTAL and would wrap to zero at W bits.
    assign in_sync   = (count_q >= SYNC_BEG) && ((BP == 0) || (count_q < SYNC_END));

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: two axis counters plus a registered decode stage
// producing sync, data-enable, pixel coordinates and line/frame pulses.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_TIMING.h_active,
    parameter int unsigned H_FP     = VGA640_TIMING.h_fp,
    parameter int unsigned H_SYNC   = VGA640_TIMING.h_sync,
    parameter int unsigned H_BP     = VGA640_TIMING.h_bp,
    parameter int unsigned V_ACTIVE = VGA640_TIMING.v_active,
    parameter int unsigned V_FP     = VGA640_TIMING.v_fp,
    parameter int unsigned V_SYNC   = VGA640_TIMING.v_sync,
    parameter int unsigned V_BP     = VGA640_TIMING.v_bp,
    parameter logic        HS_POL   = VGA640_TIMING.hs_pol,
    parameter logic        VS_POL   = VGA640_TIMING.vs_pol,
    localparam int unsigned HW      = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int unsigned VW      = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic [HW-1:0] PIX_X,
    output logic [VW-1:0] PIX_Y,
    output logic          LINE_START,
    output logic          FRAME_START
);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          v_inc;

    assign v_inc = CE && h_wrap;

    sync_axis_counter #(
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP)
    ) u_h (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (CE),
        .count    (hcnt),
        .wrap     (h_wrap),
        .in_active(h_active),
        .in_sync  (h_sync)
    );

    sync_axis_counter #(
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP)
    ) u_v (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (v_inc),
        .count    (vcnt),
        .wrap     (v_wrap),
        .in_active(v_active),
        .in_sync  (v_sync)
    );

    // The last line of a frame is always blanking for any sane timing set.
    a_last_line_blank: assert property (@(posedge CLK) disable iff (RST) v_wrap |-> !v_active);

    logic          hs_d, hs_q;
    logic          vs_d, vs_q;
    logic          de_d, de_q;
    logic [HW-1:0] x_d, x_q;
    logic [VW-1:0] y_d, y_q;
    logic          ls_d, ls_q;
    logic          fs_d, fs_q;

    always_comb begin
        de_d = h_active && v_active;
        hs_d = h_sync ? HS_POL : ~HS_POL;
        vs_d = v_sync ? VS_POL : ~VS_POL;
        x_d  = de_d ? hcnt : '0;
        y_d  = de_d ? vcnt : '0;
        ls_d = (hcnt == '0);
        fs_d = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (CE) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_DE      = de_q;
    assign PIX_X       = x_q;
    assign PIX_Y       = y_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 timing for line-level behaviour and a tiny
// 8x6 raster for frame-level, stall and reset corner cases.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst, d_ce, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_rst, s_ce, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [2:0] s_x, s_y;

    video_timing_gen u_dflt (
        .CLK        (clk),
        .RST        (d_rst),
        .CE         (d_ce),
        .VGA_HS     (d_hs),
        .VGA_VS     (d_vs),
        .VGA_DE     (d_de),
        .PIX_X      (d_x),
        .PIX_Y      (d_y),
        .LINE_START (d_ls),
        .FRAME_START(d_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_small (
        .CLK        (clk),
        .RST        (s_rst),
        .CE         (s_ce),
        .VGA_HS     (s_hs),
        .VGA_VS     (s_vs),
        .VGA_DE     (s_de),
        .PIX_X      (s_x),
        .PIX_Y      (s_y),
        .LINE_START (s_ls),
        .FRAME_START(s_fs)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic ce;
        logic hs;
        logic vs;
        logic de;
        int   x;
        int   y;
        logic ls;
        logic fs;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int de_err, hs_err, x_err, ls_err, misc_err, de_cnt, hs_low;
        int frz_err, period, found;
        int s_de_cnt, s_vs_low, s_hs_hi, s_ls_cnt, s_first_vs, s_extra_fs, s_vs_bad;
        logic prev_vs;

        //          rst   ce    hs    vs    de    x  y  ls    fs
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};

        d_rst = 1'b1;
        d_ce  = 1'b1;
        s_rst = 1'b1;
        s_ce  = 1'b0;

        // ---- default timing: reset, first line, CE stall ----
        repeat (5) tick();
        check("rst.hs", int'(d_hs), 1);
        check("rst.vs", int'(d_vs), 1);
        check("rst.de", int'(d_de), 0);
        check("rst.x",  int'(d_x),  0);
        check("rst.ls", int'(d_ls), 0);
        check("rst.fs", int'(d_fs), 0);

        d_rst = 1'b0;
        de_err = 0; hs_err = 0; x_err = 0; ls_err = 0; misc_err = 0; de_cnt = 0; hs_low = 0;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (k == 1) begin
                check("first.de", int'(d_de), 1);
                check("first.hs", int'(d_hs), 1);
                check("first.vs", int'(d_vs), 1);
                check("first.fs", int'(d_fs), 1);
                check("first.y",  int'(d_y),  0);
            end
            if (d_de !== (k <= 640)) de_err++;
            if (d_hs !== !(k >= 657 && k <= 752)) hs_err++;
            if (int'(d_x) != ((k <= 640) ? k - 1 : 0)) x_err++;
            if (d_ls !== (k == 1) || d_fs !== (k == 1)) ls_err++;
            if (d_vs !== 1'b1 || d_y != 10'd0) misc_err++;
            if (d_de === 1'b1) de_cnt++;
            if (d_hs === 1'b0) hs_low++;
        end
        check("line.de_window", de_err, 0);
        check("line.hs_window", hs_err, 0);
        check("line.pix_x", x_err, 0);
        check("line.pulses", ls_err, 0);
        check("line.vs_y", misc_err, 0);
        check("line.de_count", de_cnt, 640);
        check("line.hs_low_count", hs_low, 96);

        tick();
        check("line2.ls", int'(d_ls), 1);
        check("line2.fs", int'(d_fs), 0);
        check("line2.x",  int'(d_x),  0);
        check("line2.y",  int'(d_y),  1);

        repeat (99) tick();
        check("stall.pre_x", int'(d_x), 99);
        d_ce = 1'b0;
        frz_err = 0;
        repeat (7) begin
            tick();
            if (d_x != 10'd99 || d_y != 10'd1 || d_de !== 1'b1 || d_hs !== 1'b1 ||
                d_vs !== 1'b1 || d_ls !== 1'b0 || d_fs !== 1'b0) frz_err++;
        end
        check("stall.frozen", frz_err, 0);
        d_ce = 1'b1;
        period = 0;
        x_err = 0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (d_ls === 1'b1) begin
                period = 106 + c;
                break;
            end
            if (int'(d_x) != ((c <= 540) ? 99 + c : 0)) x_err++;
        end
        check("stall.line_period", period, 807);
        check("stall.pix_x_seq", x_err, 0);
        check("stall.next_y", int'(d_y), 2);

        // ---- small raster: table-driven vectors ----
        for (int i = 0; i < 19; i++) begin
            s_rst = vecs[i].rst;
            s_ce  = vecs[i].ce;
            tick();
            check($sformatf("vec%0d.hs", i), int'(s_hs), int'(vecs[i].hs));
            check($sformatf("vec%0d.vs", i), int'(s_vs), int'(vecs[i].vs));
            check($sformatf("vec%0d.de", i), int'(s_de), int'(vecs[i].de));
            check($sformatf("vec%0d.x",  i), int'(s_x),  vecs[i].x);
            check($sformatf("vec%0d.y",  i), int'(s_y),  vecs[i].y);
            check($sformatf("vec%0d.ls", i), int'(s_ls), int'(vecs[i].ls));
            check($sformatf("vec%0d.fs", i), int'(s_fs), int'(vecs[i].fs));
        end

        // ---- small raster: one full frame between FRAME_START pulses ----
        s_rst = 1'b0;
        s_ce  = 1'b1;
        found = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (s_fs === 1'b1) begin
                found = c;
                break;
            end
        end
        check("frame.first_fs_wait", found, 47);
        s_de_cnt = 0; s_vs_low = 0; s_hs_hi = 0; s_ls_cnt = 0;
        s_first_vs = -1; s_extra_fs = 0; s_vs_bad = 0;
        prev_vs = s_vs;
        for (int n = 0; n < 48; n++) begin
            if (n > 0) begin
                tick();
                if (s_fs === 1'b1) s_extra_fs++;
                if (s_vs !== prev_vs && s_ls !== 1'b1) s_vs_bad++;
            end
            prev_vs = s_vs;
            if (s_de === 1'b1) s_de_cnt++;
            if (s_hs === 1'b1) s_hs_hi++;
            if (s_ls === 1'b1) s_ls_cnt++;
            if (s_vs === 1'b0) begin
                s_vs_low++;
                if (s_first_vs < 0) s_first_vs = n;
            end
        end
        tick();
        check("frame.de_count", s_de_cnt, 12);
        check("frame.vs_low_count", s_vs_low, 8);
        check("frame.vs_first", s_first_vs, 32);
        check("frame.hs_high_count", s_hs_hi, 12);
        check("frame.line_starts", s_ls_cnt, 6);
        check("frame.extra_fs", s_extra_fs, 0);
        check("frame.vs_off_line", s_vs_bad, 0);
        check("frame.period_fs", int'(s_fs), 1);

        // ---- small raster: mid-frame reset at line 2, pixel 3 ----
        found = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (s_y == 3'd2 && s_x == 3'd3) begin
                found = 1;
                break;
            end
        end
        check("midrst.reach", found, 1);
        s_rst = 1'b1;
        tick();
        check("midrst.de", int'(s_de), 0);
        check("midrst.x",  int'(s_x),  0);
        check("midrst.y",  int'(s_y),  0);
        check("midrst.fs", int'(s_fs), 0);
        s_rst = 1'b0;
        tick();
        check("midrst.restart_fs", int'(s_fs), 1);
        check("midrst.restart_de", int'(s_de), 1);
        check("midrst.restart_y",  int'(s_y),  0);
        tick();
        check("midrst.next_x", int'(s_x), 1);

        // ---- small raster: reset inside sync pulses cuts them short ----
        found = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (s_vs === 1'b0) begin
                found = 1;
                break;
            end
        end
        check("vscut.reach", found, 1);
        s_rst = 1'b1;
        tick();
        check("vscut.vs", int'(s_vs), 1);
        s_rst = 1'b0;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (s_hs === 1'b1) begin
                found = c;
                break;
            end
        end
        check("hscut.reach", found, 6);
        s_rst = 1'b1;
        tick();
        check("hscut.hs", int'(s_hs), 0);
        s_rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
